ps2_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard over the open-drain PS2_CLK/PS2_DATA pair. It runs on the 50 MHz clock alongside `ps2_rx` and drives only pull-down enables. The top level builds the tri-states as `PS2_CLK = kclk_oe ? 0 : z` and `PS2_DATA = kdata_oe ? 0 : z`. `tx_busy` gates `ps2_rx` so the receiver ignores device clocks during a transmission.

---
 rtl/ps2_tx.sv | 177 +++++++++++++++++
 tb/tb_ps2_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter. It sends one command byte to the device
// by driving only the pull-down enables of the open-drain clock and data pads.
module ps2_tx #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kclk_in,
  input  logic       kdata_in,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  if (CLK_FREQ_HZ <= 0 || INHIBIT_CYCLES < 3 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_tx: invalid parameter values");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_INHIBIT, ST_REQ, ST_SHIFT, ST_ACK, ST_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [10:0]      sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nack_q, nack_d;
  logic             kclk_oe_q, kclk_oe_d;
  logic             kdata_oe_q, kdata_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [2:0]       kclk_sync_q;
  logic [1:0]       kdata_sync_q;
  logic             kclk_s, kdata_s, fall;

  // Synchronizers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kclk_sync_q  <= 3'b111;
      kdata_sync_q <= 2'b11;
    end else begin
      kclk_sync_q  <= {kclk_sync_q[1:0], kclk_in};
      kdata_sync_q <= {kdata_sync_q[0], kdata_in};
    end
  end

  assign kclk_s  = kclk_sync_q[1];
  assign kdata_s = kdata_sync_q[1];
  assign fall    = kclk_sync_q[2] & ~kclk_sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      cnt_q      <= '0;
      nack_q     <= 1'b0;
      kclk_oe_q  <= 1'b0;
      kdata_oe_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      nack_q     <= nack_d;
      kclk_oe_q  <= kclk_oe_d;
      kdata_oe_q <= kdata_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_q;
    nack_d     = nack_q;
    kclk_oe_d  = kclk_oe_q;
    kdata_oe_d = kdata_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          sr_d       = {1'b1, ~^tx_data, tx_data, 1'b0};
          bit_cnt_d  = '0;
          // Starting at 1 makes INHIBIT plus the REQ cycle total INHIBIT_CYCLES clock-low cycles.
          cnt_d      = CNT_W'(1);
          nack_d     = 1'b0;
          busy_d     = 1'b1;
          kclk_oe_d  = 1'b1;
          kdata_oe_d = 1'b0;
          state_d    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          kdata_oe_d = ~sr_q[0];
          state_d    = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REQ: begin
        kclk_oe_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        cnt_d = fall ? '0 : cnt_q + CNT_W'(1);
        if (fall) begin
          sr_d       = {1'b1, sr_q[10:1]};
          kdata_oe_d = ~sr_q[1];
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        cnt_d = fall ? '0 : cnt_q + CNT_W'(1);
        if (fall) begin
          nack_d    = kdata_s;
          bit_cnt_d = bit_cnt_q + 4'd1;
          state_d   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = fall ? '0 : cnt_q + CNT_W'(1);
        if (kclk_s && kdata_s) begin
          done_d  = 1'b1;
          error_d = nack_q;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog: a device that stops clocking must not hold the bus forever.
    if ((state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE) &&
        cnt_q == TO_LAST) begin
      kclk_oe_d  = 1'b0;
      kdata_oe_d = 1'b0;
      done_d     = 1'b1;
      error_d    = 1'b1;
      busy_d     = 1'b0;
      cnt_d      = '0;
      state_d    = ST_IDLE;
    end
  end

  assign kclk_oe  = kclk_oe_q;
  assign kdata_oe = kdata_oe_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_error = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a device model clocks bits in on rising edges
// and answers with ACK, NACK or silence.
module tb_ps2_tx;

  localparam int INH = 50;
  localparam int TO  = 1000;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       bfm_clk = 1'b1;
  logic       bfm_data = 1'b1;
  logic       kclk_oe, kdata_oe, tx_busy, tx_done, tx_error;
  logic       kclk_pad, kdata_pad;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_run = 0, req_run = 0, inh_len = 0, req_len = 0;

  assign kclk_pad  = ~kclk_oe & bfm_clk;
  assign kdata_pad = ~kdata_oe & bfm_data;

  ps2_tx #(
    .CLK_FREQ_HZ(50_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kclk_in(kclk_pad),
    .kdata_in(kdata_pad),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .kclk_oe(kclk_oe),
    .kdata_oe(kdata_oe),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #10 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  // Pulse counters and clock-low / request-window lengths.
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    if (kclk_oe) begin
      inh_run <= inh_run + 1;
      if (kdata_oe) req_run <= req_run + 1;
    end else if (inh_run != 0) begin
      inh_len <= inh_run;
      req_len <= req_run;
      inh_run <= 0;
      req_run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bfm(input logic ack, input int stop_after,
                     output logic [9:0] bits, output logic start_ok);
    int n;
    bits = '0;
    n = 0;
    while (kclk_oe && n < INH + 100) begin
      @(posedge clk); #2;
      n++;
    end
    start_ok = !kclk_oe && !kdata_pad;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) bfm_data = ~ack;
      repeat (H) @(posedge clk);
      #2 bfm_clk = 1'b0;
      repeat (H) @(posedge clk);
      #2;
      if (i <= 10) bits[i-1] = kdata_pad;
      bfm_clk = 1'b1;
      if (i == 11) bfm_data = 1'b1;
      if (i == stop_after) break;
    end
  endtask

  task automatic xfer(input string tag, input logic [7:0] d, input logic ack,
                      input int stop_after, input logic exp_err,
                      input logic [9:0] exp_bits, input bit poke, input bit chk_bits);
    int d0, e0, b0;
    logic [9:0] bits;
    logic start_ok;
    d0 = done_cnt; e0 = err_cnt; b0 = both_cnt;
    @(posedge clk); #2;
    chk({tag, "_idle_busy"}, tx_busy, 1'b0);
    tx_data = d;
    tx_start = 1'b1;
    @(posedge clk); #2;
    tx_start = 1'b0;
    chk({tag, "_accept"}, {tx_busy, kclk_oe, kdata_oe}, 3'b110);
    fork
      bfm(ack, stop_after, bits, start_ok);
      if (poke) begin
        repeat (100) @(posedge clk);
        #2 tx_data = 8'h55;
        tx_start = 1'b1;
        @(posedge clk); #2;
        tx_start = 1'b0;
      end
    join
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #2;
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_error"}, err_cnt - e0, {31'd0, exp_err});
    chk({tag, "_err_with_done"}, both_cnt - b0, {31'd0, exp_err});
    chk({tag, "_released"}, {kclk_oe, kdata_oe, tx_busy}, 3'b000);
    chk({tag, "_inhibit_len"}, inh_len, INH);
    chk({tag, "_req_len"}, req_len, 1);
    chk({tag, "_start_bit"}, start_ok, 1'b1);
    if (chk_bits) chk({tag, "_bits"}, bits, exp_bits);
  endtask

  initial begin
    int d0;
    logic [9:0] bits;
    logic start_ok;

    repeat (3) @(posedge clk);
    #2 chk("reset_outputs", {kclk_oe, kdata_oe, tx_busy, tx_done, tx_error}, 5'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // bits = {stop, parity, data}
    xfer("ack_ed", 8'hED, 1'b1, 0, 1'b0, 10'h3ED, 1'b0, 1'b1);
    xfer("ack_f4", 8'hF4, 1'b1, 0, 1'b0, 10'h2F4, 1'b0, 1'b1);
    xfer("ack_00", 8'h00, 1'b1, 0, 1'b0, 10'h300, 1'b0, 1'b1);
    xfer("nack_ff", 8'hFF, 1'b0, 0, 1'b1, 10'h3FF, 1'b0, 1'b1);
    xfer("timeout", 8'hED, 1'b1, 4, 1'b1, 10'h000, 1'b0, 1'b0);
    xfer("after_to", 8'hF4, 1'b1, 0, 1'b0, 10'h2F4, 1'b0, 1'b1);
    xfer("busy_ign", 8'hED, 1'b1, 0, 1'b0, 10'h3ED, 1'b1, 1'b1);

    // Reset in the middle of the data bits.
    d0 = done_cnt;
    @(posedge clk); #2;
    tx_data = 8'hED;
    tx_start = 1'b1;
    @(posedge clk); #2;
    tx_start = 1'b0;
    bfm(1'b1, 5, bits, start_ok);
    repeat (3) @(posedge clk);
    #3 chk("rst_pre_kdata", {kdata_oe, tx_busy}, 2'b11);
    reset = 1'b0;
    #1 chk("rst_async", {kclk_oe, kdata_oe, tx_busy, tx_done, tx_error}, 5'b0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    repeat (TO + 200) @(posedge clk);
    #2 chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle", {kclk_oe, kdata_oe, tx_busy}, 3'b000);

    xfer("post_rst", 8'hED, 1'b1, 0, 1'b0, 10'h3ED, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
